permutation_sequencer_1234: RTL

Upstream feeder for the `permute1234` permuter. Accepts one 128-bit bot (monotonic boolean function) at a time over a valid/ready handshake and emits it once per permutation of variables 1–4, up to 24 beats. Each beat drives the `selectedSet` / `selectedPermutationInSet` select pair that the permuter consumes. A one-entry pending buffer lets the next bot arrive while the current one is still being swept, so consecutive sweeps run without bubbles.

---
 rtl/permutation_sequencer_1234_if.sv | 28 ++
 rtl/permutation_sequencer_1234.sv | 110 +++++++++++
 2 files changed

// File: rtl/permutation_sequencer_1234_if.sv
// Bot input handshake and per-permutation beat output bus of the permutation sequencer.
interface permutation_sequencer_1234_if #(
  parameter int WIDTH     = 128,
  parameter int TAG_WIDTH = 8
);
  logic [WIDTH-1:0]     in_bot;
  logic [TAG_WIDTH-1:0] in_tag;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     out_bot;
  logic [1:0]           out_set;
  logic [2:0]           out_perm_in_set;
  logic [TAG_WIDTH-1:0] out_tag;
  logic                 out_first;
  logic                 out_last;
  logic                 out_valid;
  logic                 out_ready;

  modport slave (
    input  in_bot, in_tag, in_valid, out_ready,
    output in_ready, out_bot, out_set, out_perm_in_set, out_tag, out_first, out_last, out_valid
  );

  modport master (
    output in_bot, in_tag, in_valid, out_ready,
    input  in_ready, out_bot, out_set, out_perm_in_set, out_tag, out_first, out_last, out_valid
  );
endinterface

// File: rtl/permutation_sequencer_1234.sv
// Sweeps each accepted bot through the 24 permutations of variables 1-4, one beat per cycle,
// with a one-entry pending buffer so consecutive bots stream without bubbles.
module permutation_sequencer_1234 #(
  parameter int WIDTH         = 128,
  parameter int TAG_WIDTH     = 8,
  parameter bit SKIP_IDENTITY = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  permutation_sequencer_1234_if.slave   bus,
  output logic                          busy,
  output logic [31:0]                   bots_done
);

  localparam logic [4:0] START = SKIP_IDENTITY ? 5'd1 : 5'd0;
  localparam logic [4:0] LAST  = 5'd23;

  typedef struct packed {
    logic [WIDTH-1:0]     bot;
    logic [TAG_WIDTH-1:0] tag;
  } entry_t;

  typedef enum logic {IDLE, RUN} state_t;

  state_t     state, stateNext;
  entry_t     active, pending;
  logic [4:0] idx;
  logic       pendValid;

  logic inAcc, outAcc, lastAcc;
  logic loadActIn, loadActPend, loadPend, advance;

  // in_ready depends only on the pending flag, so no path from out_ready to in_ready.
  assign inAcc   = bus.in_valid && !pendValid;
  assign outAcc  = (state == RUN) && bus.out_ready;
  assign lastAcc = outAcc && (idx == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext   = state;
    loadActIn   = 1'b0;
    loadActPend = 1'b0;
    loadPend    = 1'b0;
    advance     = 1'b0;
    case (state)
      IDLE: begin
        if (inAcc) begin
          loadActIn = 1'b1;
          stateNext = RUN;
        end
      end
      RUN: begin
        if (lastAcc) begin
          if (pendValid)  loadActPend = 1'b1;
          else if (inAcc) loadActIn   = 1'b1;
          else            stateNext   = IDLE;
        end else begin
          advance  = outAcc;
          loadPend = inAcc;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active    <= '0;
      pending   <= '0;
      idx       <= 5'd0;
      pendValid <= 1'b0;
      bots_done <= 32'd0;
    end else begin
      if (loadActIn) begin
        active <= '{bot: bus.in_bot, tag: bus.in_tag};
        idx    <= START;
      end else if (loadActPend) begin
        active <= pending;
        idx    <= START;
      end else if (advance) begin
        idx <= idx + 5'd1;
      end

      if (loadPend) begin
        pending   <= '{bot: bus.in_bot, tag: bus.in_tag};
        pendValid <= 1'b1;
      end else if (loadActPend) begin
        pendValid <= 1'b0;
      end

      if (lastAcc) bots_done <= bots_done + 32'd1;
    end
  end

  assign bus.in_ready        = !pendValid;
  assign bus.out_valid       = (state == RUN);
  assign bus.out_bot         = active.bot;
  assign bus.out_tag         = active.tag;
  assign bus.out_set         = idx[1:0];
  assign bus.out_perm_in_set = idx[4:2];
  // Gated by RUN so the markers read 0 out of reset and while idle.
  assign bus.out_first       = (state == RUN) && (idx == START);
  assign bus.out_last        = (state == RUN) && (idx == LAST);
  assign busy                = (state == RUN) || pendValid;

endmodule
